// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: owns the PC, fetches over a request/ready handshake and drives the IF/ID register.
// A taken redirect inserts one bubble; a wrong-path fetch in flight is drained in DISCARD.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        shouldStall,
    input  logic        shouldJumpOrBranch,
    input  logic [31:0] jumpOrBranchTarget,
    output logic        instructionMemoryRequest,
    output logic [31:0] instructionMemoryAddress,
    input  logic        instructionMemoryReady,
    input  logic [31:0] instructionMemoryData,
    output logic [31:0] instruction,
    output logic [31:0] pc_4,
    output logic        instructionValid
);

    typedef enum logic [1:0] {StFetch, StDiscard, StBuffered} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buffer_q, buffer_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_4_q, pc_4_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        if_bubble;
    logic        if_load;
    logic [31:0] if_word;

    // A stalled decode cannot redirect; its branch is re-evaluated once the stall clears.
    assign redirect = shouldJumpOrBranch && !shouldStall;
    assign target   = jumpOrBranchTarget & ~32'd3;
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (redirect) begin
                    if (!instructionMemoryReady) state_d = StDiscard;
                end else if (shouldStall && instructionMemoryReady) begin
                    state_d = StBuffered;
                end
            end
            StDiscard: begin
                if (instructionMemoryReady) state_d = StFetch;
            end
            StBuffered: begin
                if (redirect || !shouldStall) state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        buffer_d  = buffer_q;
        pending_d = pending_q;
        instr_d   = instr_q;
        pc_4_d    = pc_4_q;
        valid_d   = valid_q;
        if_bubble = 1'b0;
        if_load   = 1'b0;
        if_word   = instructionMemoryData;
        unique case (state_q)
            StFetch: begin
                if (redirect) begin
                    if_bubble = 1'b1;
                    if (instructionMemoryReady) pc_d = target;
                    else                        pending_d = target;
                end else if (shouldStall) begin
                    if (instructionMemoryReady) buffer_d = instructionMemoryData;
                end else if (instructionMemoryReady) begin
                    if_load = 1'b1;
                    pc_d    = pc_plus4;
                end else begin
                    if_bubble = 1'b1;
                end
            end
            StDiscard: begin
                if (redirect) pending_d = target;
                if (!shouldStall) if_bubble = 1'b1;
                if (instructionMemoryReady) pc_d = redirect ? target : pending_q;
            end
            StBuffered: begin
                if (redirect) begin
                    if_bubble = 1'b1;
                    pc_d      = target;
                end else if (!shouldStall) begin
                    if_load = 1'b1;
                    if_word = buffer_q;
                    pc_d    = pc_plus4;
                end
            end
            default: ;
        endcase
        if (if_bubble) begin
            instr_d = 32'd0;
            pc_4_d  = 32'd0;
            valid_d = 1'b0;
        end else if (if_load) begin
            instr_d = if_word;
            pc_4_d  = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            buffer_q  <= 32'd0;
            pending_q <= 32'd0;
            instr_q   <= 32'd0;
            pc_4_q    <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            buffer_q  <= buffer_d;
            pending_q <= pending_d;
            instr_q   <= instr_d;
            pc_4_q    <= pc_4_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        instructionMemoryRequest = (state_q != StBuffered);
        instructionMemoryAddress = instructionMemoryRequest ? pc_q : 32'd0;
        instruction              = instr_q;
        pc_4                     = pc_4_q;
        instructionValid         = valid_q;
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage; memory returns a fixed function of the address.
module tb_instruction_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        should_stall;
    logic        should_jb;
    logic [31:0] jb_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic [31:0] instruction;
    logic [31:0] pc_4;
    logic        instr_valid;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .shouldStall             (should_stall),
        .shouldJumpOrBranch      (should_jb),
        .jumpOrBranchTarget      (jb_target),
        .instructionMemoryRequest(mem_req),
        .instructionMemoryAddress(mem_addr),
        .instructionMemoryReady  (mem_ready),
        .instructionMemoryData   (mem_data),
        .instruction             (instruction),
        .pc_4                    (pc_4),
        .instructionValid        (instr_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    assign mem_data = mem_word(mem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                              input logic v);
        check({tag, ".instr"}, instruction, ins);
        check({tag, ".pc_4"}, pc_4, p4);
        check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        should_stall = 1'b0;
        should_jb    = 1'b0;
        jb_target    = 32'd0;
        mem_ready    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Apply inputs, let one rising edge pass, sample at the falling edge.
    task automatic cycle(input logic stall, input logic jb, input logic [31:0] tgt,
                         input logic rdy);
        should_stall = stall;
        should_jb    = jb;
        jb_target    = tgt;
        mem_ready    = rdy;
        @(negedge clock);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        should_stall = 1'b0;
        should_jb = 1'b0;
        jb_target = 32'd0;
        mem_ready = 1'b1;
        #2;
        check("rst.req", {31'd0, mem_req}, 32'd1);
        check("rst.addr", mem_addr, 32'd0);
        check_ifid("rst", 32'd0, 32'd0, 1'b0);

        // Ready tied high: one instruction per cycle
        do_reset();
        check("flow.addr0", mem_addr, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            check("flow.addr", mem_addr, 32'(4 * k));
            check_ifid("flow", mem_word(32'(4 * k - 4)), 32'(4 * k), 1'b1);
        end

        // Ready every third cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 2; w++) begin
                cycle(1'b0, 1'b0, 32'd0, 1'b0);
                check("slow.hold_addr", mem_addr, 32'(4 * i));
                check_ifid("slow.bubble", 32'd0, 32'd0, 1'b0);
            end
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            check("slow.next_addr", mem_addr, 32'(4 * i + 4));
            check_ifid("slow.word", mem_word(32'(4 * i)), 32'(4 * i + 4), 1'b1);
        end

        // Stall for two cycles with ready at pc=8
        do_reset();
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("stall.pre_addr", mem_addr, 32'd8);
        for (int s = 0; s < 2; s++) begin
            cycle(1'b1, 1'b0, 32'd0, 1'b1);
            check("stall.req", {31'd0, mem_req}, 32'd0);
            check("stall.addr", mem_addr, 32'd0);
            check_ifid("stall.hold", mem_word(32'd4), 32'd8, 1'b1);
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_ifid("stall.release", mem_word(32'd8), 32'd12, 1'b1);
        check("stall.next_addr", mem_addr, 32'd12);
        check("stall.next_req", {31'd0, mem_req}, 32'd1);

        // Redirect to 0x103 while the fetch at 16 is waiting
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("redir.pre_addr", mem_addr, 32'd16);
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        check_ifid("redir.bubble", 32'd0, 32'd0, 1'b0);
        check("redir.hold_addr", mem_addr, 32'd16);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        check("redir.hold_addr2", mem_addr, 32'd16);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("redir.new_addr", mem_addr, 32'h0000_0100);
        check_ifid("redir.dropped", 32'd0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_ifid("redir.target", mem_word(32'h100), 32'h104, 1'b1);

        // Redirect while stalled is ignored
        do_reset();
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        check("ign.addr", mem_addr, 32'd8);
        check_ifid("ign.hold", mem_word(32'd4), 32'd8, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_ifid("ign.resume", mem_word(32'd8), 32'd12, 1'b1);
        check("ign.next_addr", mem_addr, 32'd12);

        // Async reset in the middle of DISCARD
        do_reset();
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0040, 1'b0);
        check("areset.pre_addr", mem_addr, 32'd4);
        should_jb = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("areset.addr", mem_addr, 32'd0);
        check("areset.req", {31'd0, mem_req}, 32'd1);
        check_ifid("areset", 32'd0, 32'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("areset.after_addr", mem_addr, 32'd4);
        check_ifid("areset.after", mem_word(32'd0), 32'd4, 1'b1);

        // PC wrap at the top of the address space
        do_reset();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        check("wrap.addr", mem_addr, 32'hFFFF_FFFC);
        check_ifid("wrap.bubble", 32'd0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_ifid("wrap.word", mem_word(32'hFFFF_FFFC), 32'd0, 1'b1);
        check("wrap.next_addr", mem_addr, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
